// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared state encoding and AXI4-Lite constants for axi_lite_master
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WR_B   = 3'd2,
    RD_A   = 3'd3,
    RD_D   = 3'd4,
    RSP    = 3'd5,
    LOCKED = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_timeout.sv
// rtl/axi_lite_master_timeout.sv - wait-state counter flagging a stalled AXI4-Lite transaction
module axi_lite_master_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic busy,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Saturates so a masked expiry can never wrap back into a false window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (busy && cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = busy && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator; AXI_MASTER_TIMEOUT_EN adds a response timeout
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [31:0]                   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [31:0]                   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp
`ifdef AXI_MASTER_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  state_t                        state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;
  logic                          aw_done;
  logic                          w_done;
  logic                          accept;
  logic                          aw_fin;
  logic                          w_fin;

  assign accept = cmd_valid & cmd_ready;
  assign aw_fin = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_fin  = w_done  | (m_axi_wvalid  & m_axi_wready);

  // AXI payloads come only from the command registers, never from cmd_*.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_arprot = PROT_DEFAULT;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic busy;
  logic progress;
  logic restart;
  logic expired;

  assign busy = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_D);

  assign progress = ((state == WR)   && aw_fin && w_fin) ||
                    ((state == WR_B) && m_axi_bvalid)    ||
                    ((state == RD_A) && m_axi_arready)   ||
                    ((state == RD_D) && m_axi_rvalid);

  assign restart = accept ||
                   ((state == WR)   && aw_fin && w_fin) ||
                   ((state == RD_A) && m_axi_arready);

  axi_lite_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .restart (restart),
    .busy    (busy),
    .expired (expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      timeout_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            if (cmd_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_A;
            end
          end
        end
        WR: begin
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            m_axi_bready <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_A: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_D;
          end
        end
        RD_D: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            if (timeout_err) begin
              addr_q  <= '0;
              wdata_q <= '0;
              wstrb_q <= '0;
              state   <= LOCKED;
            end else begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
`else
            cmd_ready <= 1'b1;
            state     <= IDLE;
`endif
          end
        end
`ifdef AXI_MASTER_TIMEOUT_EN
        LOCKED: begin
          state <= LOCKED;
        end
`endif
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase

`ifdef AXI_MASTER_TIMEOUT_EN
      // A handshake landing on the expiry cycle wins over the timeout.
      if (expired && !progress) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        rsp_resp      <= RESP_SLVERR;
        rsp_rdata     <= '0;
        rsp_valid     <= 1'b1;
        timeout_err   <= 1'b1;
        state         <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - self-checking bench for axi_lite_master with a cycle-stepped slave model
module tb_axi_lite_master;

  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [31:0]   m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
`ifdef AXI_MASTER_TIMEOUT_EN
  logic          timeout_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] slave_mem [4];
  logic [31:0] ref_mem   [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp)
`ifdef AXI_MASTER_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  // Issues one command and plays the slave; cycle k counts from the accept cycle (k = 0).
  task automatic run_txn(
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [31:0] wd,
    input  logic [3:0]  ws,
    input  int          aw_dly,
    input  int          w_dly,
    input  int          b_dly,
    input  int          ar_dly,
    input  int          r_dly,
    input  int          rsp_dly,
    input  logic [1:0]  sresp,
    output logic [31:0] rd,
    output logic [1:0]  rr,
    output int          rsp_at,
    output int          aw_n,
    output int          w_n,
    output int          viol,
    output int          acc_at,
    output int          hs_at,
    output bit          stuck
  );
    int aw_c, w_c, ar_c, b_w, r_w, rsp_w, c;
    bit aw_h, w_h, ar_h, b_h, r_h, done, aw_now, w_now, ar_now, b_now, r_now;
    logic [3:0]  obs_addr;
    logic [31:0] obs_wd;
    logic [3:0]  obs_ws;
    logic [31:0] merged;
    aw_c = 0; w_c = 0; ar_c = 0; b_w = 0; r_w = 0; rsp_w = 0;
    aw_h = 0; w_h = 0; ar_h = 0; b_h = 0; r_h = 0; done = 0;
    obs_addr = '0; obs_wd = '0; obs_ws = '0;
    rd = '0; rr = '0; rsp_at = -1; aw_n = 0; w_n = 0; viol = 0;
    acc_at = -1; hs_at = -1; stuck = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    c = 0;
    while (!cmd_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      stuck = 1;
      return;
    end
    acc_at = cyc;
    @(posedge clk);
    for (int k = 1; k < 200 && !done; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (cmd_ready) viol++;
      if (m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) viol++;
      if (k == 1 && wr && !(m_axi_awvalid && m_axi_wvalid)) viol++;
      if (k == 1 && !wr && !m_axi_arvalid) viol++;
      if (!wr && (m_axi_awvalid || m_axi_wvalid)) viol++;
      if (wr && m_axi_arvalid) viol++;
      if (m_axi_awvalid) begin
        aw_n++;
        if (m_axi_awaddr !== addr || aw_h) viol++;
      end
      if (m_axi_wvalid) begin
        w_n++;
        if (m_axi_wdata !== wd || m_axi_wstrb !== ws || w_h) viol++;
      end
      if (m_axi_arvalid && (m_axi_araddr !== addr || ar_h)) viol++;
      if (m_axi_bready && !(aw_h && w_h)) viol++;
      if (m_axi_rready && !ar_h) viol++;
      m_axi_awready = m_axi_awvalid && (aw_c >= aw_dly);
      m_axi_wready  = m_axi_wvalid && (w_c >= w_dly);
      m_axi_arready = m_axi_arvalid && (ar_c >= ar_dly);
      m_axi_bvalid  = aw_h && w_h && !b_h && (b_w >= b_dly);
      m_axi_bresp   = m_axi_bvalid ? sresp : 2'b00;
      m_axi_rvalid  = ar_h && !r_h && (r_w >= r_dly);
      m_axi_rdata   = m_axi_rvalid ? slave_mem[addr[3:2]] : 32'h0;
      m_axi_rresp   = m_axi_rvalid ? sresp : 2'b00;
      rsp_ready     = 1'b0;
      if (rsp_valid) begin
        if (rsp_at < 0) begin
          rsp_at = k;
          rd = rsp_rdata;
          rr = rsp_resp;
        end
        rsp_ready = (rsp_w >= rsp_dly);
        rsp_w++;
        if (rsp_ready) begin
          hs_at = cyc;
          done = 1;
        end
      end
      aw_now = m_axi_awvalid && m_axi_awready;
      w_now  = m_axi_wvalid && m_axi_wready;
      ar_now = m_axi_arvalid && m_axi_arready;
      b_now  = m_axi_bvalid && m_axi_bready;
      r_now  = m_axi_rvalid && m_axi_rready;
      if (aw_now) obs_addr = m_axi_awaddr;
      if (w_now) begin
        obs_wd = m_axi_wdata;
        obs_ws = m_axi_wstrb;
      end
      @(posedge clk);
      if (m_axi_awvalid && !aw_now) aw_c++;
      if (m_axi_wvalid && !w_now) w_c++;
      if (m_axi_arvalid && !ar_now) ar_c++;
      if (aw_h && w_h && !b_now) b_w++;
      if (ar_h && !r_now) r_w++;
      if ((aw_now || w_now) && (aw_h || aw_now) && (w_h || w_now)) begin
        merged = slave_mem[obs_addr[3:2]];
        for (int b = 0; b < 4; b++)
          if (obs_ws[b]) merged[8*b +: 8] = obs_wd[8*b +: 8];
        slave_mem[obs_addr[3:2]] = merged;
      end
      aw_h = aw_h || aw_now;
      w_h  = w_h || w_now;
      ar_h = ar_h || ar_now;
      b_h  = b_h || b_now;
      r_h  = r_h || r_now;
    end
    #1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_bresp = '0; m_axi_rresp = '0; rsp_ready = 1'b0;
    if (!done) stuck = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cmd_ready got=%0b want=1", cmd_ready);
    end
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_handshakes got=%b want=000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid});
    end
    total++;
    if ({rsp_rdata, rsp_resp, m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== '0) begin
      bad++;
      $display("FAIL reset_regs got rdata=%h resp=%h awaddr=%h wdata=%h wstrb=%h want all 0",
               rsp_rdata, rsp_resp, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
    end
  endtask

  task automatic test_write_zero_wait();
    logic [31:0] rd; logic [1:0] rr; int rsp_at, aw_n, w_n, viol, acc_at, hs_at; bit stuck;
    run_txn(1'b1, 4'h4, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00,
            rd, rr, rsp_at, aw_n, w_n, viol, acc_at, hs_at, stuck);
    ref_mem[1] = 32'h0000_00A5;
    total++;
    if (stuck || rsp_at !== 3) begin
      bad++;
      $display("FAIL wr0_latency got=%0d stuck=%0b want=3", rsp_at, stuck);
    end
    total++;
    if (rr !== 2'b00 || rd !== 32'h0) begin
      bad++;
      $display("FAIL wr0_rsp got resp=%0d rdata=%h want resp=0 rdata=0", rr, rd);
    end
    total++;
    if (viol !== 0 || aw_n !== 1 || w_n !== 1) begin
      bad++;
      $display("FAIL wr0_protocol got viol=%0d aw=%0d w=%0d want 0/1/1", viol, aw_n, w_n);
    end
  endtask

  task automatic test_write_aw_delay();
    logic [31:0] rd; logic [1:0] rr; int rsp_at, aw_n, w_n, viol, acc_at, hs_at; bit stuck;
    run_txn(1'b1, 4'h0, 32'hDEAD_BEEF, 4'h5, 3, 0, 0, 0, 0, 0, 2'b00,
            rd, rr, rsp_at, aw_n, w_n, viol, acc_at, hs_at, stuck);
    ref_mem[0] = {ref_mem[0][31:24], 8'hAD, ref_mem[0][15:8], 8'hEF};
    total++;
    if (aw_n !== 4 || w_n !== 1) begin
      bad++;
      $display("FAIL awdly_valid_cycles got aw=%0d w=%0d want aw=4 w=1", aw_n, w_n);
    end
    total++;
    if (viol !== 0 || stuck || rsp_at !== 6 || rr !== 2'b00) begin
      bad++;
      $display("FAIL awdly_rsp got viol=%0d stuck=%0b at=%0d resp=%0d want 0/0/6/0", viol, stuck, rsp_at, rr);
    end
  endtask

  task automatic test_read_wait();
    logic [31:0] rd; logic [1:0] rr; int rsp_at, aw_n, w_n, viol, acc_at, hs_at; bit stuck;
    slave_mem[2] = 32'h1234_5678;
    ref_mem[2]   = 32'h1234_5678;
    run_txn(1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 2, 1, 2'b10,
            rd, rr, rsp_at, aw_n, w_n, viol, acc_at, hs_at, stuck);
    total++;
    if (rd !== 32'h1234_5678 || rr !== 2'b10) begin
      bad++;
      $display("FAIL rd_wait_data got rdata=%h resp=%0d want 12345678/2", rd, rr);
    end
    total++;
    if (viol !== 0 || stuck || rsp_at !== 5) begin
      bad++;
      $display("FAIL rd_wait_timing got viol=%0d stuck=%0b at=%0d want 0/0/5", viol, stuck, rsp_at);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] rr; int rsp_at, aw_n, w_n, viol, acc_at, hs_at; bit stuck;
    int hs1, viol1;
    run_txn(1'b1, 4'hC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 0, 2'b11,
            rd, rr, rsp_at, aw_n, w_n, viol, acc_at, hs_at, stuck);
    ref_mem[3] = 32'hCAFE_F00D;
    hs1 = hs_at;
    viol1 = viol;
    total++;
    if (rr !== 2'b11) begin
      bad++;
      $display("FAIL b2b_wr_decerr got=%0d want=3", rr);
    end
    run_txn(1'b0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00,
            rd, rr, rsp_at, aw_n, w_n, viol, acc_at, hs_at, stuck);
    total++;
    if (acc_at !== hs1 + 1) begin
      bad++;
      $display("FAIL b2b_accept got=%0d want=%0d", acc_at, hs1 + 1);
    end
    total++;
    if (viol1 + viol !== 0 || rd !== ref_mem[3] || rsp_at !== 3) begin
      bad++;
      $display("FAIL b2b_read got viol=%0d rdata=%h at=%0d want 0/%h/3", viol1 + viol, rd, rsp_at, ref_mem[3]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic [1:0] rr; int rsp_at, aw_n, w_n, viol, acc_at, hs_at; bit stuck;
    logic wr; logic [1:0] word, resp; logic [31:0] wd; logic [3:0] ws;
    int awd, wdl, bd, ard, rdl, exp_at;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      word = 2'($urandom_range(0, 3));
      resp = 2'($urandom_range(0, 3));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      awd = $urandom_range(0, 3); wdl = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      ard = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      run_txn(wr, {word, 2'b00}, wd, ws, awd, wdl, bd, ard, rdl, $urandom_range(0, 2), resp,
              rd, rr, rsp_at, aw_n, w_n, viol, acc_at, hs_at, stuck);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
        exp_at = 1 + ((awd > wdl) ? awd : wdl) + 1 + bd + 1;
      end else begin
        exp_at = 1 + ard + 1 + rdl + 1;
      end
      total++;
      if (stuck || viol !== 0 || rsp_at !== exp_at || rr !== resp ||
          rd !== (wr ? 32'h0 : ref_mem[word])) begin
        bad++;
        $display("FAIL rand_txn%0d wr=%0b got at=%0d resp=%0d rdata=%h viol=%0d stuck=%0b want at=%0d resp=%0d rdata=%h",
                 t, wr, rsp_at, rr, rd, viol, stuck, exp_at, resp, wr ? 32'h0 : ref_mem[word]);
      end
    end
  endtask

  task automatic test_reset_in_wr_b();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'h5A5A_5A5A; cmd_wstrb = 4'hF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    @(posedge clk);
    #1;
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    @(negedge clk);
    total++;
    if (m_axi_bready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wrb_bready got=%0b want=1", m_axi_bready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid} !== 6'b0) begin
      bad++;
      $display("FAIL rst_wrb_abort got=%b want=000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wrb_cmd_ready got=%0b want=1", cmd_ready);
    end
  endtask

`ifdef AXI_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic [1:0] rr; int rsp_at, aw_n, w_n, viol, acc_at, hs_at; bit stuck;
    int seen;
    run_txn(1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 0, 2'b00,
            rd, rr, rsp_at, aw_n, w_n, viol, acc_at, hs_at, stuck);
    total++;
    if (stuck || rsp_at !== TO + 1 || rr !== 2'b10 || rd !== 32'h0) begin
      bad++;
      $display("FAIL tmo_rsp got at=%0d resp=%0d rdata=%h stuck=%0b want %0d/2/0", rsp_at, rr, rd, stuck, TO + 1);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_err got=%0b want=1", timeout_err);
    end
    seen = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready || m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || m_axi_bready || m_axi_rready) seen++;
    end
    cmd_valid = 1'b0;
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL tmo_locked got active_cycles=%0d want=0", seen);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL tmo_clear got err=%0b cmd_ready=%0b want 0/1", timeout_err, cmd_ready);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin
      slave_mem[i] = 32'h1111_1111 * (i + 1);
      ref_mem[i]   = 32'h1111_1111 * (i + 1);
    end
    test_reset();
    test_write_zero_wait();
    test_write_aw_delay();
    test_read_wait();
    test_back_to_back();
    test_random();
    test_reset_in_wr_b();
`ifdef AXI_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
Single-outstanding AXI4-Lite initiator. It converts a simple command/response stream into AXI4-Lite read and write transactions. It drives uart_axi-style register slaves, for example from a UART debug bridge or a testbench-free on-chip sequencer. It is the initiator end of the same AXI4-Lite interface the UART register block responds to.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, width of the AXI address bus and cmd_addr.
- TIMEOUT_CYCLES, 1024, cycles to wait for the B or R response before declaring a timeout (used only with the optional feature).

Ports:
- s_axi_aclk  in  1  system clock; every flop in the block uses this clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid is also high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  target byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid is also high.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- m_axi_awvalid out 1; m_axi_awready in 1; m_axi_awaddr out C_M_AXI_ADDR_WIDTH; m_axi_awprot out 3.
- m_axi_wvalid out 1; m_axi_wready in 1; m_axi_wdata out 32; m_axi_wstrb out 4.
- m_axi_bvalid in 1; m_axi_bready out 1; m_axi_bresp in 2.
- m_axi_arvalid out 1; m_axi_arready in 1; m_axi_araddr out C_M_AXI_ADDR_WIDTH; m_axi_arprot out 3.
- m_axi_rvalid in 1; m_axi_rready out 1; m_axi_rdata in 32; m_axi_rresp in 2.

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE.
  - All valid and ready outputs are 0, except cmd_ready.
  - Address, data, strobe and rsp_* registers are 0.
  - cmd_ready = 1 in IDLE once reset is released.
- cmd_ready is high only in IDLE. A cmd_valid & cmd_ready cycle latches addr, wdata, wstrb and write into registers. The AXI outputs drive from these registers only; there is no combinational path from cmd_* to m_axi_*.
- awprot = arprot = 3'b000 always.
- States:
  - IDLE: accept a command. The next state is WR if cmd_write = 1, otherwise RD_A.
  - WR: awvalid and wvalid assert together on the cycle after acceptance.
    - Each valid drops independently on its own handshake, and each side has a done flag.
    - AW and W may complete in the same cycle or in either order.
    - When both are done, go to WR_B.
  - WR_B: bready = 1. On bvalid, capture bresp into rsp_resp and set rsp_rdata = 0. Go to RSP.
  - RD_A: arvalid = 1 until arready, then go to RD_D.
  - RD_D: rready = 1. On rvalid, capture rdata and rresp. Go to RSP.
  - RSP: rsp_valid = 1. On rsp_ready, go to IDLE.
- A valid, once asserted, is held with its payload stable until its handshake. The master never waits for a ready signal before asserting valid.
- Minimum latency with a zero-wait slave:
  - Accept at cycle 0.
  - AW/W or AR handshake at cycle 1.
  - B or R handshake at cycle 2.
  - rsp_valid at cycle 3.
- Back-to-back: a new command is accepted the cycle after the rsp_ready handshake.
- bready and rready assert only in WR_B and RD_D. A B or R response arriving in any other state is not acknowledged.
- SLVERR and DECERR responses pass through unchanged. No retry is attempted.
- Reset mid-transaction aborts the transaction immediately. All valids drop to 0 and the block returns to IDLE.

Optional Feature:
- Macro AXI_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to WR, WR_B, RD_A or RD_D and increments every cycle spent in those states.
  - When the counter reaches TIMEOUT_CYCLES, the block sets rsp_resp = 2'b10 and rsp_rdata = 0, and enters RSP.
  - A sticky output timeout_err (out, 1) goes to 1. Only reset clears timeout_err.
  - After RSP completes, the FSM enters LOCKED. In LOCKED, cmd_ready = 0 and all AXI outputs are 0 until reset.
- Disabled: the block waits forever. The timeout_err port and the LOCKED state do not exist.

Decomposition:
- Package axi_lite_pkg holds:
  - state enum (IDLE, WR, WR_B, RD_A, RD_D, RSP, LOCKED);
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - PROT_DEFAULT = 3'b000.
- One natural sub-module: axi_lite_master_timeout, holding the counter and the timeout compare. It is instantiated only under AXI_MASTER_TIMEOUT_EN.

Test Plan:
- Write with a zero-wait slave: addr 0x4, wdata 0xA5, wstrb 0xF.
  - awvalid and wvalid both high at cycle 1 with awaddr = 0x4 and wdata = 0xA5.
  - rsp_valid at cycle 3 with rsp_resp = 0.
- Write where awready is delayed 3 cycles and wready is immediate.
  - wvalid drops after 1 cycle; awvalid is held 4 cycles.
  - bready asserts only after both handshakes; the response is correct.
- Read addr 0x8 where the slave returns 0x1234_5678 with rresp = 2'b10 after a 2-cycle wait.
  - rsp_rdata = 0x1234_5678 and rsp_resp = 2'b10.
- Back-to-back write then read with rsp_ready held high.
  - The second command is accepted on the cycle after the first rsp handshake.
  - cmd_ready is 0 throughout the transaction.
- Reset asserted while in WR_B.
  - All m_axi valid and ready outputs are 0 in the same cycle.
  - cmd_ready = 1 after release.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a read to a slave that never asserts arready:
  - rsp_resp = 2'b10 after 16 cycles in RD_A;
  - timeout_err = 1;
  - cmd_ready stays 0 until reset.
